serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 5 +
 rtl/full_adder_cell.sv | 11 +
 rtl/serial_adder_ctrl.sv | 73 +++++++
 tb/tb_serial_adder_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding (ST_IDLE/ST_RUN/ST_DONE) and default operand width shared by the serial adder files
package serial_adder_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder; ports x, y, cin -> s, cout
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder over one shared full_adder_cell; ports clk, rst, start, a, b, cin -> busy, done, sum, cout (+ ovf when SERIAL_ADDER_OVF_EN is defined)
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_nxt;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0] cnt;
    logic carry, cell_s, cell_c, last;
    assign last = cnt == CW'(WIDTH - 1);
    full_adder_cell u_cell (
        .x   (sa[0]),
        .y   (sb[0]),
        .cin (carry),
        .s   (cell_s),
        .cout(cell_c)
    );
    always_ff @(posedge clk)
        state <= rst ? ST_IDLE : state_nxt;
    always_comb
        state_nxt = state == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
                    state == ST_RUN  ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
    always_comb begin
        busy = state != ST_IDLE;
        done = state == ST_DONE;
    end
    always_ff @(posedge clk)
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            sum   <= {cell_s, sum[WIDTH-1:1]};
            carry <= cell_c;
            cnt   <= cnt + CW'(1);
            if (last)
                cout <= cell_c;
        end
`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk)
        if (rst)
            ovf <= 1'b0;
        else if (state == ST_RUN && last)
            ovf <= carry ^ cell_c;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized scoreboard bench for serial_adder_ctrl against an arithmetic reference model
module tb_serial_adder_ctrl;
    localparam int W = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic ovf;
`endif
    typedef struct packed {
        logic [W:0] res;
        logic       ov;
    } exp_t;
    exp_t q[$];
    exp_t last_exp;
    int errors = 0, checks = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        exp_t e;
        int u, sv;
        u  = int'(ma) + int'(mb) + int'(mc);
        sv = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        e.res = u[W:0];
        e.ov  = sv > (1 << (W - 1)) - 1 || sv < -(1 << (W - 1));
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (done) begin
            if (q.size() == 0)
                chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", sum, e.res[W-1:0]);
                chk("cout", cout, e.res[W]);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", ovf, e.ov);
`endif
            end
        end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        int n;
        @(negedge clk);
        a = ta;
        b = tb;
        cin = tc;
        start = 1'b1;
        last_exp = model(ta, tb, tc);
        q.push_back(last_exp);
        @(posedge clk);
        #1;
        chk("busy_after_start", busy, 1);
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < W + 10);
        chk("latency", n, W + 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("reset_ovf", ovf, 0);
`endif
        rst = 1'b0;
        do_op(8'h3C, 8'h5A, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1);
        do_op(8'h7F, 8'h01, 1'b0);
        do_op(8'h80, 8'h80, 1'b0);
        do_op(8'h10, 8'h20, 1'b0);
        repeat (20) begin
            @(negedge clk);
            chk("hold_sum", sum, last_exp.res[W-1:0]);
            chk("hold_cout", cout, last_exp.res[W]);
            chk("hold_done", done, 0);
            chk("hold_busy", busy, 0);
        end
        for (int i = 0; i < 3 * (W + 2); i++) begin
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            start = 1'b1;
            if (i % (W + 2) == 0)
                q.push_back(model(a, b, cin));
            @(negedge clk);
        end
        start = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        chk("held_start_drain", q.size(), 0);
        @(negedge clk);
        a = 8'hA5;
        b = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        rst = 1'b0;
        repeat (W + 3) @(negedge clk);
        do_op(8'hA5, 8'h3C, 1'b1);
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(W'($urandom), W'($urandom), 1'($urandom));
        end
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
